// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode-side
// valid/ready instruction handshake. master = fetch unit, slave = environment.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              misalign_err;

  modport master (
    output imem_addr, inst_valid, inst_data, inst_pc, misalign_err,
    input  imem_rdata, redirect_valid, redirect_target, inst_ready
  );

  modport slave (
    input  imem_addr, inst_valid, inst_data, inst_pc, misalign_err,
    output imem_rdata, redirect_valid, redirect_target, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, combinational imem access and a small instruction queue.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects into a sticky HALT.
module fetch_unit #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       QUEUE_DEPTH = 2
) (
  input logic         clk,
  input logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [DATA_W-1:0] q_data [QUEUE_DEPTH];
  logic [ADDR_W-1:0] q_pc   [QUEUE_DEPTH];

  logic              valid;
  logic              pop, push, flush, trap;
  logic [ADDR_W-1:0] target_aligned;

  assign valid          = (count != '0);
  assign target_aligned = {bus.redirect_target[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_n = state;
    flush   = 1'b0;
    push    = 1'b0;
    trap    = 1'b0;
    pop     = valid & bus.inst_ready;
    case (state)
      RUN: begin
        if (bus.redirect_valid) begin
          flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (bus.redirect_target[1:0] != 2'b00) begin
            trap    = 1'b1;
            state_n = HALT;
          end
`endif
        end else begin
          push = (count < DEPTH_C) | pop;
        end
      end
      HALT: ;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_n;
  end

  // Redirect wins over any same-cycle push/pop; a popped head in that cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      pc     <= target_aligned;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        pc     <= pc + ADDR_W'(4);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= bus.imem_rdata;
      q_pc[wr_ptr]   <= pc;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    misalign <= 1'b0;
    else if (trap) misalign <= 1'b1;
  end
  assign bus.misalign_err = misalign;
`else
  logic unused_trap;
  assign unused_trap      = trap ^ (^bus.redirect_target[1:0]);
  assign bus.misalign_err = 1'b0;
`endif

  assign bus.imem_addr  = pc;
  assign bus.inst_valid = valid;
  assign bus.inst_data  = valid ? q_data[rd_ptr] : '0;
  assign bus.inst_pc    = valid ? q_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-level reference model with a per-cycle
// compare process, plus directed literal checks and a randomized stream.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   checks;
  int   failures;

  logic [31:0] mem [16384];

  fetch_unit_if #(.ADDR_W(16), .DATA_W(32)) bus0 ();
  fetch_unit_if #(.ADDR_W(16), .DATA_W(32)) bus1 ();

  fetch_unit #(.ADDR_W(16), .DATA_W(32), .RESET_PC(16'h0000), .QUEUE_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  fetch_unit #(.ADDR_W(16), .DATA_W(32), .RESET_PC(16'hFFF8), .QUEUE_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  assign bus0.imem_rdata = mem[bus0.imem_addr[15:2]];
  assign bus1.imem_rdata = mem[bus1.imem_addr[15:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched {pc,data} pairs, fetch pc and trap state.
  ent_t        mq[$];
  logic [15:0] m_pc     = 16'h0000;
  logic        m_err    = 1'b0;
  logic        m_halted = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pc     = 16'h0000;
      m_err    = 1'b0;
      m_halted = 1'b0;
    end else if (bus0.redirect_valid && !m_halted) begin
      mq.delete();
      m_pc = bus0.redirect_target & 16'hFFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (bus0.redirect_target[1:0] != 2'b00) begin
        m_err    = 1'b1;
        m_halted = 1'b1;
      end
`endif
    end else begin
      if (mq.size() > 0 && bus0.inst_ready) void'(mq.pop_front());
      if (!m_halted && mq.size() < DEPTH) begin
        mq.push_back('{pc: m_pc, data: mem[m_pc[15:2]]});
        m_pc = m_pc + 16'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_addr", 32'(bus0.imem_addr), 32'(m_pc));
      check("inst_valid", 32'(bus0.inst_valid), 32'(mq.size() != 0));
      check("inst_pc", 32'(bus0.inst_pc), (mq.size() != 0) ? 32'(mq[0].pc) : 32'h0);
      check("inst_data", bus0.inst_data, (mq.size() != 0) ? mq[0].data : 32'h0);
      check("misalign_err", 32'(bus0.misalign_err), 32'(m_err));
    end
  end

  logic [31:0] prog [4];
  logic [15:0] tgt;

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    for (int unsigned i = 0; i < 16384; i++) mem[i] = $urandom;
    prog[0] = 32'h00410033; prog[1] = 32'h00418033;
    prog[2] = 32'h00A7F013; prog[3] = 32'h00309663;
    for (int i = 0; i < 4; i++) mem[i] = prog[i];
    mem[11]     = 32'h00B00513;
    mem[16382]  = 32'hDEAD0001;
    mem[16383]  = 32'hDEAD0002;
    bus0.inst_ready = 1'b0; bus0.redirect_valid = 1'b0; bus0.redirect_target = '0;
    bus1.inst_ready = 1'b1; bus1.redirect_valid = 1'b0; bus1.redirect_target = '0;

    // Reset values
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(bus0.inst_valid), 32'h0);
    check("rst_data", bus0.inst_data, 32'h0);
    check("rst_pc", 32'(bus0.inst_pc), 32'h0);
    check("rst_addr", 32'(bus0.imem_addr), 32'h0000);
    check("rst_err", 32'(bus0.misalign_err), 32'h0);
    check("rst_addr1", 32'(bus1.imem_addr), 32'hFFF8);
    #2 rst_n = 1'b1; bus0.inst_ready = 1'b1;

    // Streaming from reset, plus wrap on the FFF8 instance
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      check("stream_valid", 32'(bus0.inst_valid), 32'h1);
      check("stream_pc", 32'(bus0.inst_pc), 32'(4 * k));
      check("stream_data", bus0.inst_data, prog[k]);
      if (k == 0) check("wrap_pc0", 32'(bus1.inst_pc), 32'hFFF8);
      if (k == 1) check("wrap_pc1", 32'(bus1.inst_pc), 32'hFFFC);
      if (k == 2) begin
        check("wrap_pc2", 32'(bus1.inst_pc), 32'h0000);
        check("wrap_data2", bus1.inst_data, 32'h00410033);
      end
      if (k == 1) check("wrap_data1", bus1.inst_data, 32'hDEAD0002);
    end

    // Stall for 5 cycles, then release
    @(posedge clk); #1 rst_n = 1'b0; bus0.inst_ready = 1'b0;
    #2 check("async_rst_valid", 32'(bus0.inst_valid), 32'h0);
    check("async_rst_addr", 32'(bus0.imem_addr), 32'h0000);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stall_pc", 32'(bus0.inst_pc), 32'h0000);
    check("stall_addr", 32'(bus0.imem_addr), 32'h0008);
    check("stall_valid", 32'(bus0.inst_valid), 32'h1);
    #1 bus0.inst_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("drain_pc1", 32'(bus0.inst_pc), 32'h0004);
    @(posedge clk); @(negedge clk);
    check("drain_pc2", 32'(bus0.inst_pc), 32'h0008);

    // Redirect while full and draining
    @(posedge clk); #1 bus0.redirect_valid = 1'b1; bus0.redirect_target = 16'h002C;
    @(posedge clk); #1 bus0.redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_valid", 32'(bus0.inst_valid), 32'h0);
    check("redir_addr", 32'(bus0.imem_addr), 32'h002C);
    @(posedge clk); @(negedge clk);
    check("redir_pc", 32'(bus0.inst_pc), 32'h002C);
    check("redir_data", bus0.inst_data, 32'h00B00513);

    // Misaligned redirect
    @(posedge clk); #1 bus0.redirect_valid = 1'b1; bus0.redirect_target = 16'h0012;
    @(posedge clk); #1 bus0.redirect_valid = 1'b0;
    @(negedge clk);
    check("mis_valid", 32'(bus0.inst_valid), 32'h0);
    check("mis_addr", 32'(bus0.imem_addr), 32'h0010);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_err", 32'(bus0.misalign_err), 32'h1);
`else
    check("mis_err", 32'(bus0.misalign_err), 32'h0);
`endif
    @(posedge clk); #1 bus0.redirect_valid = 1'b1; bus0.redirect_target = 16'h0020;
    @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("halt_valid", 32'(bus0.inst_valid), 32'h0);
`else
    check("mis_head_pc", 32'(bus0.inst_pc), 32'h0010);
`endif
    @(posedge clk); #1 bus0.redirect_valid = 1'b0;
    @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("halt_addr", 32'(bus0.imem_addr), 32'h0010);
    check("halt_err", 32'(bus0.misalign_err), 32'h1);
`else
    check("redir2_addr", 32'(bus0.imem_addr), 32'h0020);
`endif

    // Asynchronous reset with a full queue
    @(posedge clk); #1 rst_n = 1'b0; bus0.inst_ready = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("full_valid", 32'(bus0.inst_valid), 32'h1);
    check("full_addr", 32'(bus0.imem_addr), 32'h0008);
    #2 rst_n = 1'b0;
    #1 check("midrst_valid", 32'(bus0.inst_valid), 32'h0);
    check("midrst_addr", 32'(bus0.imem_addr), 32'h0000);
    check("midrst_pc", 32'(bus0.inst_pc), 32'h0000);
    check("midrst_addr1", 32'(bus1.imem_addr), 32'hFFF8);
    @(negedge clk); #1 rst_n = 1'b1;

    // Randomized stream against the model
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      if (cyc % 100 == 99) begin
        rst_n = 1'b0;
        bus0.redirect_valid = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
      end else begin
        bus0.inst_ready     = ($urandom_range(0, 9) < 7);
        bus0.redirect_valid = ($urandom_range(0, 11) == 0);
        tgt = 16'($urandom);
        if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
        bus0.redirect_target = tgt;
      end
    end
    @(posedge clk); #1 bus0.redirect_valid = 1'b0;
    @(negedge clk); #1 chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
